// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Parametrised modulo-N up/down counter with enable, parallel
//               load, clock-enable prescaler, wrap/saturate mode, terminal
//               count and roll-over flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH    - bit width of q and load_val
//   MODULUS  - count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//   PRESCALE - enabled cycles per count step (>= 1)
//   SATURATE - 0: wrap at the range limits, 1: hold at the range limits
// Ports:
//   clk      in   clock, all state updates on posedge
//   reset    in   synchronous active-low reset
//   en       in   count enable, advances the prescaler
//   up       in   direction, 1 = increment, 0 = decrement
//   load     in   parallel load strobe (wins over en)
//   load_val in   load value, clamped to MODULUS-1
//   q        out  current count (registered)
//   tc       out  terminal count for the current direction (combinational)
//   roll     out  one-cycle pulse after a step taken at the boundary
// ============================================================================
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             roll
);

    // Prescaler is at least one bit wide so PRESCALE=1 still has a legal vector.
    localparam int                c_PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]  c_MAX    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0]  c_ZERO   = '0;

    logic [WIDTH-1:0]  r_q;
    logic [c_PS_W-1:0] r_ps;
    logic              r_roll;

    logic              w_step;
    logic              w_at_bound;
    logic [WIDTH-1:0]  w_q_step;
    logic [WIDTH-1:0]  w_load_clamped;

    // A step fires on the enabled cycle that completes the prescale period.
    assign w_step = en && (r_ps == c_PS_MAX);

    // Out-of-range load values clamp to the top of the count range.
    assign w_load_clamped = (load_val > c_MAX) ? c_MAX : load_val;

    // Next count for a step. The boundary is compared against MODULUS-1 rather
    // than relying on natural WIDTH-bit overflow, so non-power-of-2 moduli wrap
    // correctly and q can never leave 0..MODULUS-1.
    always_comb begin
        w_at_bound = 1'b0;
        w_q_step   = r_q;
        if (up) begin
            if (r_q == c_MAX) begin
                w_at_bound = 1'b1;
                w_q_step   = (SATURATE != 0) ? r_q : c_ZERO;
            end else begin
                w_q_step   = r_q + 1'b1;
            end
        end else begin
            if (r_q == c_ZERO) begin
                w_at_bound = 1'b1;
                w_q_step   = (SATURATE != 0) ? r_q : c_MAX;
            end else begin
                w_q_step   = r_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q    <= c_ZERO;
            r_ps   <= '0;
            r_roll <= 1'b0;
        end else if (load) begin
            // Load discards any partial prescale count and suppresses the step.
            r_q    <= w_load_clamped;
            r_ps   <= '0;
            r_roll <= 1'b0;
        end else if (en) begin
            if (w_step) begin
                r_q    <= w_q_step;
                r_ps   <= '0;
                r_roll <= w_at_bound;
            end else begin
                r_ps   <= r_ps + 1'b1;
                r_roll <= 1'b0;
            end
        end else begin
            r_roll <= 1'b0;
        end
    end

    assign q    = r_q;
    assign roll = r_roll;
    assign tc   = up ? (r_q == c_MAX) : (r_q == c_ZERO);

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter
// Description : Directed self-checking bench for mod_counter. Three instances
//               cover wrap mode, saturate mode and a prescaled counter, all
//               with MODULUS=10 on a 4-bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

    logic clk;
    logic reset;

    // wrap instance: MODULUS=10, PRESCALE=1, SATURATE=0
    logic       a_en, a_up, a_load;
    logic [3:0] a_val, a_q;
    logic       a_tc, a_roll;
    // saturate instance: MODULUS=10, PRESCALE=1, SATURATE=1
    logic       s_en, s_up, s_load;
    logic [3:0] s_val, s_q;
    logic       s_tc, s_roll;
    // prescaled instance: MODULUS=10, PRESCALE=3, SATURATE=0
    logic       p_en, p_up, p_load;
    logic [3:0] p_val, p_q;
    logic       p_tc, p_roll;

    int total;
    int bad;

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(a_en), .up(a_up), .load(a_load),
        .load_val(a_val), .q(a_q), .tc(a_tc), .roll(a_roll)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(s_en), .up(s_up), .load(s_load),
        .load_val(s_val), .q(s_q), .tc(s_tc), .roll(s_roll)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_pre (
        .clk(clk), .reset(reset), .en(p_en), .up(p_up), .load(p_load),
        .load_val(p_val), .q(p_q), .tc(p_tc), .roll(p_roll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int exp_q1 [12];
        int exp_q2 [5];
        int exp_r2 [5];
        int exp_p5 [6];
        exp_q1 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        exp_q2 = '{2, 1, 0, 9, 8};
        exp_r2 = '{0, 0, 0, 1, 0};
        exp_p5 = '{0, 0, 1, 1, 1, 2};

        total = 0;
        bad   = 0;
        reset = 1'b0;
        a_en = 1'b0; a_up = 1'b1; a_load = 1'b0; a_val = 4'd0;
        s_en = 1'b0; s_up = 1'b1; s_load = 1'b0; s_val = 4'd0;
        p_en = 1'b0; p_up = 1'b1; p_load = 1'b0; p_val = 4'd0;

        // ---- reset state ----
        tick();
        check("rst_q",    32'(a_q), 0);
        check("rst_roll", 32'(a_roll), 0);
        check("rst_tc_up", 32'(a_tc), 0);
        a_up = 1'b0;
        #1;
        check("rst_tc_down", 32'(a_tc), 1);
        a_up = 1'b1;
        check("rst_pre_q", 32'(p_q), 0);
        reset = 1'b1;

        // ---- 1: wrap count up 12 cycles ----
        a_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("up_q",    32'(a_q), exp_q1[i]);
            check("up_tc",   32'(a_tc), (exp_q1[i] == 9) ? 1 : 0);
            check("up_roll", 32'(a_roll), (i == 9) ? 1 : 0);
        end

        // ---- 2: load 3, count down 5 cycles ----
        a_en = 1'b0; a_load = 1'b1; a_val = 4'd3;
        tick();
        check("ld3_q",    32'(a_q), 3);
        check("ld3_roll", 32'(a_roll), 0);
        a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dn_q",    32'(a_q), exp_q2[i]);
            check("dn_tc",   32'(a_tc), (exp_q2[i] == 0) ? 1 : 0);
            check("dn_roll", 32'(a_roll), exp_r2[i]);
        end

        // ---- 3: clamped load and load-over-enable ----
        a_en = 1'b0; a_up = 1'b1; a_load = 1'b1; a_val = 4'd13;
        tick();
        check("clamp13_q", 32'(a_q), 9);
        a_val = 4'd10;
        tick();
        check("clamp10_q", 32'(a_q), 9);
        a_en = 1'b1; a_val = 4'd5;
        tick();
        check("ld_en_q",    32'(a_q), 5);
        check("ld_en_roll", 32'(a_roll), 0);
        a_load = 1'b0;
        tick();
        check("after_ld_q", 32'(a_q), 6);

        // ---- 4: saturate mode ----
        s_load = 1'b1; s_val = 4'd8;
        tick();
        check("sat_ld_q", 32'(s_q), 8);
        s_load = 1'b0; s_en = 1'b1; s_up = 1'b1;
        tick();
        check("sat_up0_q",    32'(s_q), 9);
        check("sat_up0_roll", 32'(s_roll), 0);
        check("sat_up0_tc",   32'(s_tc), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_up_q",    32'(s_q), 9);
            check("sat_up_roll", 32'(s_roll), 1);
        end
        s_en = 1'b0; s_load = 1'b1; s_val = 4'd1;
        tick();
        check("sat_ld1_q",    32'(s_q), 1);
        check("sat_ld1_roll", 32'(s_roll), 0);
        s_load = 1'b0; s_en = 1'b1; s_up = 1'b0;
        tick();
        check("sat_dn0_q",    32'(s_q), 0);
        check("sat_dn0_roll", 32'(s_roll), 0);
        tick();
        check("sat_dn1_q",    32'(s_q), 0);
        check("sat_dn1_roll", 32'(s_roll), 1);
        check("sat_dn1_tc",   32'(s_tc), 1);
        s_en = 1'b0;
        tick();
        check("sat_idle_roll", 32'(s_roll), 0);

        // ---- 5: prescale by 3 ----
        p_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pre_q", 32'(p_q), exp_p5[i]);
        end
        tick();                       // prescaler now 1, q=2
        check("pre_part_q", 32'(p_q), 2);
        p_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_hold_q", 32'(p_q), 2);
        end
        p_en = 1'b1;
        tick();                       // prescaler 2
        check("pre_res1_q", 32'(p_q), 2);
        tick();                       // step: partial count was kept
        check("pre_res2_q", 32'(p_q), 3);

        // ---- 6: reset mid-count (q=6, prescaler=1) ----
        for (int i = 0; i < 10; i++) tick();
        check("pre_mid_q", 32'(p_q), 6);
        reset = 1'b0;
        tick();
        check("mid_rst_q",    32'(p_q), 0);
        check("mid_rst_roll", 32'(p_roll), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_q", 32'(p_q), 0);
        end
        reset = 1'b1;
        tick();
        check("post_rst1_q", 32'(p_q), 0);
        tick();
        check("post_rst2_q", 32'(p_q), 0);
        tick();
        check("post_rst3_q", 32'(p_q), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
